// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard scheduler: stalls a branch/jr whose sources are not yet forwardable,
// flushes IF/ID on a resolved taken branch or jump, and keeps saturating stall/flush counts.
module branch_hazard_ctrl #(
   parameter int ALU_EX_STALLS   = 1,
   parameter int LOAD_EX_STALLS  = 2,
   parameter int LOAD_MEM_STALLS = 1,
   parameter int STAT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Hold,
   input  logic              Branch_ID,
   input  logic              UsesRt_ID,
   input  logic              BranchTaken_ID,
   input  logic              Jump_ID,
   input  logic [4:0]        rs_ID,
   input  logic [4:0]        rt_ID,
   input  logic [4:0]        Rw_EX,
   input  logic              RegWrite_EX,
   input  logic              MemRead_EX,
   input  logic [4:0]        Rw_MEM,
   input  logic              MemRead_MEM,
   output logic              Stall,
   output logic              Flush_IFID,
   output logic [STAT_W-1:0] StallCnt,
   output logic [STAT_W-1:0] FlushCnt
);

   localparam int MAX_EX = (ALU_EX_STALLS > LOAD_EX_STALLS) ? ALU_EX_STALLS : LOAD_EX_STALLS;
   localparam int MAX_N  = (MAX_EX > LOAD_MEM_STALLS) ? MAX_EX : LOAD_MEM_STALLS;
   localparam int REM_W  = (MAX_N > 4) ? $clog2(MAX_N) : 2;
   localparam int NEED_W = REM_W + 1;

   typedef enum logic {IDLE, STALL} state_t;

   state_t              state_q, state_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [NEED_W-1:0]   need_rs, need_rt, need;

   // Stall cycles one source needs; the EX producer is newer than MEM, so it shadows MEM for that register.
   function automatic logic [NEED_W-1:0] src_need(
      input logic [4:0] r,
      input logic [4:0] rw_ex,
      input logic       regwrite_ex,
      input logic       memread_ex,
      input logic [4:0] rw_mem,
      input logic       memread_mem
   );
      logic [NEED_W-1:0] n;
      n = '0;
      if (r != 5'd0) begin
         if ((regwrite_ex || memread_ex) && (r == rw_ex))
            n = memread_ex ? NEED_W'(LOAD_EX_STALLS) : NEED_W'(ALU_EX_STALLS);
         else if (memread_mem && (r == rw_mem))
            n = NEED_W'(LOAD_MEM_STALLS);
      end
      return n;
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
      return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
   endfunction

   always_comb begin
      need_rs = src_need(rs_ID, Rw_EX, RegWrite_EX, MemRead_EX, Rw_MEM, MemRead_MEM);
      need_rt = UsesRt_ID ? src_need(rt_ID, Rw_EX, RegWrite_EX, MemRead_EX, Rw_MEM, MemRead_MEM) : '0;
      if (!Branch_ID)
         need = '0;
      else
         need = (need_rs > need_rt) ? need_rs : need_rt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // The IDLE cycle is the first stall cycle, so STALL is entered with N-2 cycles still to go after it.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      stall_cnt_d = sat_inc(stall_cnt_q, Stall && !Hold);
      flush_cnt_d = sat_inc(flush_cnt_q, Flush_IFID && !Hold);
      if (!Hold) begin
         case (state_q)
            IDLE: begin
               if (need > NEED_W'(1)) begin
                  state_d = STALL;
                  rem_d   = REM_W'(need - NEED_W'(2));
               end
            end
            STALL: begin
               if (rem_q == '0)
                  state_d = IDLE;
               else
                  rem_d = rem_q - REM_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      Stall      = (state_q == STALL) || (need != '0);
      Flush_IFID = !Stall && ((Branch_ID && BranchTaken_ID) || Jump_ID);
      StallCnt   = stall_cnt_q;
      FlushCnt   = flush_cnt_q;
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus randomized traffic
// against a remaining-stall-cycles reference model.
module tb_branch_hazard_ctrl;

   localparam int STAT_W = 8;
   localparam int ALU_N  = 1;
   localparam int LEX_N  = 2;
   localparam int LMEM_N = 1;
   localparam int CMAX   = (1 << STAT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, Hold, Branch_ID, UsesRt_ID, BranchTaken_ID, Jump_ID;
   logic [4:0]        rs_ID, rt_ID, Rw_EX, Rw_MEM;
   logic              RegWrite_EX, MemRead_EX, MemRead_MEM;
   logic              Stall, Flush_IFID;
   logic [STAT_W-1:0] StallCnt, FlushCnt;

   branch_hazard_ctrl #(
      .ALU_EX_STALLS(ALU_N), .LOAD_EX_STALLS(LEX_N), .LOAD_MEM_STALLS(LMEM_N), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .reset(reset), .Hold(Hold), .Branch_ID(Branch_ID), .UsesRt_ID(UsesRt_ID),
      .BranchTaken_ID(BranchTaken_ID), .Jump_ID(Jump_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
      .Rw_EX(Rw_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Rw_MEM(Rw_MEM),
      .MemRead_MEM(MemRead_MEM), .Stall(Stall), .Flush_IFID(Flush_IFID),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   int n_vec = 0;
   int n_err = 0;
   int m_left = 0;   // further stall cycles owed after the current one
   int m_scnt = 0;
   int m_fcnt = 0;

   function automatic int op_need(input logic [4:0] r);
      if (r == 5'd0) return 0;
      if ((RegWrite_EX || MemRead_EX) && r == Rw_EX) return MemRead_EX ? LEX_N : ALU_N;
      if (MemRead_MEM && r == Rw_MEM) return LMEM_N;
      return 0;
   endfunction

   function automatic int ref_need();
      int a, b;
      if (!Branch_ID) return 0;
      a = op_need(rs_ID);
      b = UsesRt_ID ? op_need(rt_ID) : 0;
      return (a > b) ? a : b;
   endfunction

   function automatic logic exp_stall();
      return (m_left > 0) || (ref_need() > 0);
   endfunction

   function automatic logic exp_flush();
      return !exp_stall() && ((Branch_ID && BranchTaken_ID) || Jump_ID);
   endfunction

   task automatic tick();
      logic s, f;
      int   n;
      s = exp_stall();
      f = exp_flush();
      n = ref_need();
      @(posedge clk);
      if (!Hold) begin
         if (s && m_scnt < CMAX) m_scnt++;
         if (f && m_fcnt < CMAX) m_fcnt++;
         if (m_left > 0) m_left--;
         else if (n > 1) m_left = n - 1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      Hold = 0; Branch_ID = 0; UsesRt_ID = 0; BranchTaken_ID = 0; Jump_ID = 0;
      rs_ID = 0; rt_ID = 0; Rw_EX = 0; RegWrite_EX = 0; MemRead_EX = 0; Rw_MEM = 0; MemRead_MEM = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      m_left = 0; m_scnt = 0; m_fcnt = 0;
      #1;
   endtask

   task automatic set_lw_hazard();
      Branch_ID = 1; UsesRt_ID = 1; rs_ID = 5'd3; rt_ID = 5'd0;
      Rw_EX = 5'd3; RegWrite_EX = 1; MemRead_EX = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", Stall); end
      n_vec++; if (Flush_IFID !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%b exp=0", Flush_IFID); end
      n_vec++; if (StallCnt !== '0) begin n_err++; $display("FAIL reset_stallcnt got=%0d exp=0", StallCnt); end
      n_vec++; if (FlushCnt !== '0) begin n_err++; $display("FAIL reset_flushcnt got=%0d exp=0", FlushCnt); end
      @(posedge clk); #1;
      reset = 1'b0;
      m_left = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic test_alu_ex();
      do_reset();
      Branch_ID = 1; UsesRt_ID = 1; rs_ID = 5'd3; rt_ID = 5'd4; Rw_EX = 5'd3; RegWrite_EX = 1;
      BranchTaken_ID = 1;
      #1;
      n_vec++; if (Stall !== 1'b1) begin n_err++; $display("FAIL alu_stall0 got=%b exp=1", Stall); end
      n_vec++; if (Flush_IFID !== 1'b0) begin n_err++; $display("FAIL alu_flush0 got=%b exp=0", Flush_IFID); end
      tick();
      Rw_EX = 0; RegWrite_EX = 0; Rw_MEM = 5'd3;
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL alu_stall1 got=%b exp=0", Stall); end
      n_vec++; if (Flush_IFID !== 1'b1) begin n_err++; $display("FAIL alu_taken_flush got=%b exp=1", Flush_IFID); end
      n_vec++; if (StallCnt !== 8'd1) begin n_err++; $display("FAIL alu_stallcnt got=%0d exp=1", StallCnt); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (FlushCnt !== 8'd1) begin n_err++; $display("FAIL alu_flushcnt got=%0d exp=1", FlushCnt); end
   endtask

   task automatic test_load_ex();
      do_reset();
      set_lw_hazard();
      #1;
      n_vec++; if (Stall !== 1'b1) begin n_err++; $display("FAIL lw_stall0 got=%b exp=1", Stall); end
      tick();
      Rw_EX = 0; RegWrite_EX = 0; MemRead_EX = 0; Rw_MEM = 5'd3; MemRead_MEM = 1;
      #1;
      n_vec++; if (Stall !== 1'b1) begin n_err++; $display("FAIL lw_stall1 got=%b exp=1", Stall); end
      tick();
      Rw_MEM = 0; MemRead_MEM = 0;
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL lw_stall2 got=%b exp=0", Stall); end
      n_vec++; if (StallCnt !== 8'd2) begin n_err++; $display("FAIL lw_stallcnt got=%0d exp=2", StallCnt); end
      tick();
   endtask

   task automatic test_no_stall();
      do_reset();
      Branch_ID = 1; UsesRt_ID = 1; rs_ID = 0; rt_ID = 0; Rw_EX = 0; RegWrite_EX = 1;
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL r0_stall got=%b exp=0", Stall); end
      tick();
      UsesRt_ID = 0; rs_ID = 5'd1; rt_ID = 5'd5; Rw_EX = 5'd5;
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL rt_unused_stall got=%b exp=0", Stall); end
      tick();
      // EX shadows a MEM load of the same register: ALU in EX wins, one stall only
      UsesRt_ID = 1; rt_ID = 5'd1; Rw_EX = 5'd1; RegWrite_EX = 1; Rw_MEM = 5'd1; MemRead_MEM = 1;
      #1;
      n_vec++; if (Stall !== 1'b1) begin n_err++; $display("FAIL ex_over_mem got=%b exp=1", Stall); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (StallCnt !== 8'd1) begin n_err++; $display("FAIL nostall_cnt got=%0d exp=1", StallCnt); end
   endtask

   task automatic test_hold();
      int seen;
      seen = 0;
      do_reset();
      set_lw_hazard();
      #1;
      if (Stall === 1'b1) seen++;
      tick();
      Hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (Stall === 1'b1) seen++;
         tick();
      end
      n_vec++; if (StallCnt !== 8'd1) begin n_err++; $display("FAIL hold_frozen_cnt got=%0d exp=1", StallCnt); end
      Hold = 0;
      #1;
      if (Stall === 1'b1) seen++;
      tick();
      idle_inputs();
      #1;
      n_vec++; if (seen != 5) begin n_err++; $display("FAIL hold_stall_cycles got=%0d exp=5", seen); end
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL hold_release got=%b exp=0", Stall); end
      n_vec++; if (StallCnt !== 8'd2) begin n_err++; $display("FAIL hold_stallcnt got=%0d exp=2", StallCnt); end
   endtask

   task automatic test_flush();
      do_reset();
      Jump_ID = 1;
      #1;
      n_vec++; if (Flush_IFID !== 1'b1) begin n_err++; $display("FAIL jump_flush got=%b exp=1", Flush_IFID); end
      tick();
      set_lw_hazard();
      BranchTaken_ID = 1;
      #1;
      n_vec++; if (Flush_IFID !== 1'b0) begin n_err++; $display("FAIL flush_while_stall got=%b exp=0", Flush_IFID); end
      tick();
      idle_inputs();
      Branch_ID = 1; BranchTaken_ID = 1;
      #1;
      n_vec++; if (Flush_IFID !== 1'b0) begin n_err++; $display("FAIL flush_in_stallstate got=%b exp=0", Flush_IFID); end
      tick();
      #1;
      n_vec++; if (Flush_IFID !== 1'b1) begin n_err++; $display("FAIL flush_taken got=%b exp=1", Flush_IFID); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (FlushCnt !== 8'd2) begin n_err++; $display("FAIL flushcnt got=%0d exp=2", FlushCnt); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_lw_hazard();
      #1;
      tick();
      #1;
      n_vec++; if (Stall !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall got=%b exp=1", Stall); end
      idle_inputs();
      reset = 1'b1;
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL midreset_stall got=%b exp=0", Stall); end
      n_vec++; if (StallCnt !== '0) begin n_err++; $display("FAIL midreset_cnt got=%0d exp=0", StallCnt); end
      reset = 1'b0;
      m_left = 0; m_scnt = 0; m_fcnt = 0;
      #1;
      tick();
      #1;
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL post_reset_stall got=%b exp=0", Stall); end
   endtask

   task automatic test_saturation();
      do_reset();
      Branch_ID = 1; rs_ID = 5'd7; Rw_EX = 5'd7; RegWrite_EX = 1;
      #1;
      repeat (CMAX + 5) tick();
      n_vec++; if (StallCnt !== STAT_W'(CMAX)) begin n_err++; $display("FAIL stallcnt_sat got=%0d exp=%0d", StallCnt, CMAX); end
      idle_inputs();
      Jump_ID = 1;
      #1;
      repeat (CMAX + 5) tick();
      n_vec++; if (FlushCnt !== STAT_W'(CMAX)) begin n_err++; $display("FAIL flushcnt_sat got=%0d exp=%0d", FlushCnt, CMAX); end
      n_vec++; if (StallCnt !== STAT_W'(CMAX)) begin n_err++; $display("FAIL stallcnt_hold got=%0d exp=%0d", StallCnt, CMAX); end
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         Hold           = ($urandom_range(0, 4) == 0);
         Branch_ID      = ($urandom_range(0, 3) != 0);
         UsesRt_ID      = 1'($urandom_range(0, 1));
         BranchTaken_ID = 1'($urandom_range(0, 1));
         Jump_ID        = ($urandom_range(0, 7) == 0);
         rs_ID          = 5'($urandom_range(0, 3));
         rt_ID          = 5'($urandom_range(0, 3));
         Rw_EX          = 5'($urandom_range(0, 3));
         RegWrite_EX    = 1'($urandom_range(0, 1));
         MemRead_EX     = ($urandom_range(0, 2) == 0);
         Rw_MEM         = 5'($urandom_range(0, 3));
         MemRead_MEM    = ($urandom_range(0, 2) == 0);
         #1;
         n_vec++; if (Stall !== exp_stall()) begin n_err++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, Stall, exp_stall()); end
         n_vec++; if (Flush_IFID !== exp_flush()) begin n_err++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, Flush_IFID, exp_flush()); end
         n_vec++; if (StallCnt !== STAT_W'(m_scnt)) begin n_err++; $display("FAIL rnd_stallcnt i=%0d got=%0d exp=%0d", i, StallCnt, m_scnt); end
         n_vec++; if (FlushCnt !== STAT_W'(m_fcnt)) begin n_err++; $display("FAIL rnd_flushcnt i=%0d got=%0d exp=%0d", i, FlushCnt, m_fcnt); end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      test_reset();
      test_alu_ex();
      test_load_ex();
      test_no_stall();
      test_hold();
      test_flush();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
